// File: rtl/kavsak_sinyalizasyon.sv
// kavsak_sinyalizasyon: round-robin intersection signal controller for N_YON approaches.
// Ports: clk, rst (sync, active-high), tick (1-clk timing strobe), gece (night request),
//        kirmizi/sari/yesil (registered lamp vectors, one bit per approach), aktif_yon.
// Each approach is served as all-red -> red+amber -> green -> amber. Phase lengths are in ticks.
// Macro GECE_MODU_EN adds a flashing-amber night state entered at all-red expiry.
module kavsak_sinyalizasyon #(
  parameter int N_YON          = 2,
  parameter int CNT_W          = 8,
  parameter int T_TUM_KIRMIZI  = 2,
  parameter int T_KIRMIZI_SARI = 1,
  parameter int T_YESIL        = 20,
  parameter int T_SARI         = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       tick,
  input  logic                       gece,
  output logic [N_YON-1:0]           kirmizi,
  output logic [N_YON-1:0]           sari,
  output logic [N_YON-1:0]           yesil,
  output logic [$clog2(N_YON)-1:0]   aktif_yon
);

  localparam int AW = $clog2(N_YON);

  localparam int T_MAX_A = (T_TUM_KIRMIZI > T_KIRMIZI_SARI) ? T_TUM_KIRMIZI : T_KIRMIZI_SARI;
  localparam int T_MAX_B = (T_YESIL > T_SARI) ? T_YESIL : T_SARI;
  localparam int T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;

  // Elaboration-time parameter sanity checks.
  if (N_YON < 2) begin : g_chk_n_yon
    $error("N_YON must be at least 2");
  end
  if (T_TUM_KIRMIZI < 1 || T_KIRMIZI_SARI < 1 || T_YESIL < 1 || T_SARI < 1) begin : g_chk_t
    $error("phase durations must be at least 1 tick");
  end
  if (longint'(T_MAX - 1) >= (longint'(1) << CNT_W)) begin : g_chk_w
    $error("CNT_W too narrow for the longest phase duration");
  end

  localparam logic [CNT_W-1:0] L_TK = CNT_W'(T_TUM_KIRMIZI - 1);
  localparam logic [CNT_W-1:0] L_KS = CNT_W'(T_KIRMIZI_SARI - 1);
  localparam logic [CNT_W-1:0] L_YE = CNT_W'(T_YESIL - 1);
  localparam logic [CNT_W-1:0] L_SA = CNT_W'(T_SARI - 1);
  localparam logic [AW-1:0]    A_LAST = AW'(N_YON - 1);

`ifdef GECE_MODU_EN
  typedef enum logic [2:0] {S_TUM_KIRMIZI, S_KIRMIZI_SARI, S_YESIL, S_SARI, S_GECE} durum_t;
`else
  typedef enum logic [1:0] {S_TUM_KIRMIZI, S_KIRMIZI_SARI, S_YESIL, S_SARI} durum_t;
`endif

  durum_t           durum, nxt_durum;
  logic [CNT_W-1:0] sayac, nxt_sayac;
  logic [AW-1:0]    nxt_a, a_inc;
  logic [N_YON-1:0] sec;
  logic [N_YON-1:0] nxt_kirmizi, nxt_sari, nxt_yesil;

`ifdef GECE_MODU_EN
  // Common level of all amber lamps while flashing at night.
  logic gece_sari, nxt_gece_sari;
`else
  logic unused_gece;
  assign unused_gece = gece;
`endif

  assign a_inc = (aktif_yon == A_LAST) ? '0 : aktif_yon + AW'(1);

  // Next-state, timer and next-lamp logic. Lamps are derived from the next
  // state so that the registered outputs change on the same edge as the state.
  always_comb begin
    nxt_durum     = durum;
    nxt_sayac     = sayac;
    nxt_a         = aktif_yon;
`ifdef GECE_MODU_EN
    nxt_gece_sari = gece_sari;
`endif

    case (durum)
      S_TUM_KIRMIZI: begin
        if (tick) begin
          if (sayac == '0) begin
`ifdef GECE_MODU_EN
            // Night request is only honoured between approaches, so a
            // running green/amber always completes first.
            if (gece) begin
              nxt_durum     = S_GECE;
              nxt_gece_sari = 1'b1;
            end else begin
              nxt_durum = S_KIRMIZI_SARI;
              nxt_a     = a_inc;
              nxt_sayac = L_KS;
            end
`else
            nxt_durum = S_KIRMIZI_SARI;
            nxt_a     = a_inc;
            nxt_sayac = L_KS;
`endif
          end else begin
            nxt_sayac = sayac - CNT_W'(1);
          end
        end
      end
      S_KIRMIZI_SARI: begin
        if (tick) begin
          if (sayac == '0) begin
            nxt_durum = S_YESIL;
            nxt_sayac = L_YE;
          end else begin
            nxt_sayac = sayac - CNT_W'(1);
          end
        end
      end
      S_YESIL: begin
        if (tick) begin
          if (sayac == '0) begin
            nxt_durum = S_SARI;
            nxt_sayac = L_SA;
          end else begin
            nxt_sayac = sayac - CNT_W'(1);
          end
        end
      end
      S_SARI: begin
        if (tick) begin
          if (sayac == '0) begin
            nxt_durum = S_TUM_KIRMIZI;
            nxt_sayac = L_TK;
          end else begin
            nxt_sayac = sayac - CNT_W'(1);
          end
        end
      end
`ifdef GECE_MODU_EN
      S_GECE: begin
        // Leaving night mode keeps aktif_yon, so the next green goes to a+1.
        if (!gece) begin
          nxt_durum = S_TUM_KIRMIZI;
          nxt_sayac = L_TK;
        end else if (tick) begin
          nxt_gece_sari = ~gece_sari;
        end
      end
`endif
      default: begin
        nxt_durum = S_TUM_KIRMIZI;
        nxt_sayac = L_TK;
      end
    endcase

    sec         = N_YON'(1) << nxt_a;
    nxt_kirmizi = '1;
    nxt_sari    = '0;
    nxt_yesil   = '0;
    case (nxt_durum)
      S_KIRMIZI_SARI: nxt_sari = sec;
      S_YESIL: begin
        nxt_kirmizi = ~sec;
        nxt_yesil   = sec;
      end
      S_SARI: begin
        nxt_kirmizi = ~sec;
        nxt_sari    = sec;
      end
`ifdef GECE_MODU_EN
      S_GECE: begin
        nxt_kirmizi = '0;
        nxt_sari    = {N_YON{nxt_gece_sari}};
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      durum     <= S_TUM_KIRMIZI;
      sayac     <= L_TK;
      aktif_yon <= A_LAST;
      kirmizi   <= '1;
      sari      <= '0;
      yesil     <= '0;
`ifdef GECE_MODU_EN
      gece_sari <= 1'b0;
`endif
    end else begin
      durum     <= nxt_durum;
      sayac     <= nxt_sayac;
      aktif_yon <= nxt_a;
      kirmizi   <= nxt_kirmizi;
      sari      <= nxt_sari;
      yesil     <= nxt_yesil;
`ifdef GECE_MODU_EN
      gece_sari <= nxt_gece_sari;
`endif
    end
  end

endmodule

// File: tb/tb_kavsak_sinyalizasyon.sv
// tb_kavsak_sinyalizasyon: drives a 2-approach and a 4-approach controller with shared
// stimulus and compares every clock against a tick-count reference model.
module tb_kavsak_sinyalizasyon;

  localparam int TK = 2;
  localparam int KS = 1;
  localparam int YE = 5;
  localparam int SA = 3;
  localparam int L  = TK + KS + YE + SA;   // ticks per approach

`ifdef GECE_MODU_EN
  localparam bit GECE_ON = 1'b1;
`else
  localparam bit GECE_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0;
  logic gece = 1'b0;

  logic [1:0] k2, s2, y2;
  logic [0:0] a2;
  logic [3:0] k4, s4, y4;
  logic [1:0] a4;

  int checks = 0;
  int failures = 0;

  // Reference model: ticks consumed since reset, plus night-mode status.
  int m_n[2];
  bit m_night[2];
  bit m_ns[2];

  always #5 clk = ~clk;

  kavsak_sinyalizasyon #(
    .N_YON(2), .CNT_W(8), .T_TUM_KIRMIZI(TK), .T_KIRMIZI_SARI(KS), .T_YESIL(YE), .T_SARI(SA)
  ) u_dut2 (
    .clk(clk), .rst(rst), .tick(tick), .gece(gece),
    .kirmizi(k2), .sari(s2), .yesil(y2), .aktif_yon(a2)
  );

  kavsak_sinyalizasyon #(
    .N_YON(4), .CNT_W(8), .T_TUM_KIRMIZI(TK), .T_KIRMIZI_SARI(KS), .T_YESIL(YE), .T_SARI(SA)
  ) u_dut4 (
    .clk(clk), .rst(rst), .tick(tick), .gece(gece),
    .kirmizi(k4), .sari(s4), .yesil(y4), .aktif_yon(a4)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", tag, $time, act, exp);
    end
  endtask

  function automatic int nyon(input int i);
    return (i == 0) ? 2 : 4;
  endfunction

  task automatic mstep(input int i, input bit r, input bit t, input bit g);
    if (r) begin
      m_n[i] = 0;
      m_night[i] = 1'b0;
      m_ns[i] = 1'b0;
    end else if (m_night[i]) begin
      if (!g) begin
        m_night[i] = 1'b0;
        m_n[i] = m_n[i] - (m_n[i] % L);   // restart the all-red of the same block
      end else if (t) begin
        m_ns[i] = !m_ns[i];
      end
    end else if (t) begin
      if (GECE_ON && g && ((m_n[i] % L) == TK - 1)) begin
        m_night[i] = 1'b1;
        m_ns[i] = 1'b1;
      end else begin
        m_n[i]++;
      end
    end
  endtask

  task automatic mexp(input int i, output logic [3:0] k, output logic [3:0] s,
                      output logic [3:0] y, output int a);
    int n;
    int blk;
    int r;
    logic [3:0] msk;
    logic [3:0] sel;
    n   = nyon(i);
    blk = m_n[i] / L;
    r   = m_n[i] % L;
    msk = 4'((1 << n) - 1);
    k = msk;
    s = 4'b0;
    y = 4'b0;
    a = (blk + n - 1) % n;
    if (m_night[i]) begin
      k = 4'b0;
      s = m_ns[i] ? msk : 4'b0;
    end else if (r >= TK) begin
      a = blk % n;
      sel = 4'(1 << a);
      if (r < TK + KS) begin
        s = sel;
      end else if (r < TK + KS + YE) begin
        k = msk & ~sel;
        y = sel;
      end else begin
        k = msk & ~sel;
        s = sel;
      end
    end
  endtask

  task automatic compare();
    logic [3:0] ek, es, ey, dk, ds, dy, dsel;
    int ea, da;
    for (int i = 0; i < 2; i++) begin
      mexp(i, ek, es, ey, ea);
      if (i == 0) begin
        dk = {2'b0, k2}; ds = {2'b0, s2}; dy = {2'b0, y2}; da = int'(a2);
      end else begin
        dk = k4; ds = s4; dy = y4; da = int'(a4);
      end
      dsel = 4'(1 << da);
      check($sformatf("kirmizi_n%0d", nyon(i)), 32'(dk), 32'(ek));
      check($sformatf("sari_n%0d", nyon(i)), 32'(ds), 32'(es));
      check($sformatf("yesil_n%0d", nyon(i)), 32'(dy), 32'(ey));
      check($sformatf("aktif_n%0d", nyon(i)), 32'(da), 32'(ea));
      check($sformatf("inv_onegreen_n%0d", nyon(i)), 32'($countones(dy) <= 1), 32'd1);
      check($sformatf("inv_greenred_n%0d", nyon(i)), 32'((dy & ~dsel) | (dy & dk)), 32'd0);
    end
  endtask

  task automatic step(input bit r, input bit t, input bit g);
    rst = r;
    tick = t;
    gece = g;
    @(posedge clk);
    mstep(0, r, t, g);
    mstep(1, r, t, g);
    #1;
    compare();
  endtask

  function automatic bit in_green0();
    int r;
    r = m_n[0] % L;
    return !m_night[0] && ((m_n[0] / L) % 2 == 0) && r >= TK + KS && r < TK + KS + YE;
  endfunction

  initial begin
    bit found;
    bit g;

    // 1: reset held with tick active
    step(1, 1, 0);
    step(1, 1, 0);
    check("t1_kirmizi", 32'(k2), 32'h3);
    check("t1_sari", 32'(s2), 32'h0);
    check("t1_yesil", 32'(y2), 32'h0);
    check("t1_aktif", 32'(a2), 32'h1);
    check("t1_aktif4", 32'(a4), 32'h3);

    // 2: tick every clock, three full N=2 cycles
    for (int c = 0; c < 66; c++) begin
      step(0, 1, 0);
      if (c == 1) check("t2_redamber0", 32'({k2, s2}), 32'b1101);
      if (c == 2) check("t2_green0", 32'(y2), 32'b01);
    end

    // 3: tick every 4th clock
    step(1, 0, 0);
    for (int c = 0; c < 200; c++) step(0, (c % 4) == 3, 0);

    // 4: reset pulse on the 3rd green clock of approach 0
    step(1, 0, 0);
    found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      step(0, 1, 0);
      if (in_green0() && (m_n[0] % L) == TK + KS + 2) found = 1'b1;
    end
    check("t4_reached_green", 32'(found), 32'd1);
    step(1, 1, 0);
    check("t4_rst_kirmizi", 32'(k2), 32'h3);
    check("t4_rst_aktif", 32'(a2), 32'h1);
    step(0, 1, 0);
    step(0, 1, 0);
    check("t4_restart_a0", 32'({a2, s2}), 32'b001);

    // 5: randomized ticks (and gece, honoured only in the night build)
    step(1, 0, 0);
    g = 1'b0;
    for (int c = 0; c < 900; c++) begin
      if ($urandom_range(0, 39) == 0) g = !g;
      step($urandom_range(0, 499) == 0, $urandom_range(0, 1) == 1, g);
    end

`ifdef GECE_MODU_EN
    // 6: night request during green of approach 0
    step(1, 0, 0);
    found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      step(0, 1, 0);
      found = in_green0();
    end
    check("t6_reached_green", 32'(found), 32'd1);
    found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      step(0, 1, 1);
      found = m_night[0];
    end
    check("t6_entered_night", 32'(found), 32'd1);
    check("t6_flash_on", 32'(s4), 32'hF);
    check("t6_no_red", 32'(k4), 32'h0);
    step(0, 1, 1);
    check("t6_flash_off", 32'(s4), 32'h0);
    step(0, 0, 1);
    step(0, 1, 1);
    check("t6_flash_on2", 32'(s4), 32'hF);
    step(0, 1, 0);
    check("t6_exit_allred", 32'(k4), 32'hF);
    step(0, 1, 0);
    step(0, 1, 0);
    check("t6_next_a1", 32'({a2, s2}), 32'b110);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog t=%0t got=timeout expected=finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
